glitchfree_clk_mux: RTL and testbench
=====================================

Name: glitchfree_clk_mux

Overview:
Glitch-free 2:1 clock multiplexer. It switches the output clock between two asynchronous source clocks under control of a select input. On a switch, the block first disables the currently selected source on that source's low phase, then enables the new source on its own low phase. clk_o therefore never carries a runt pulse and never sees both sources at once. It sits at the clock-generation level, ahead of any downstream clock tree.

Parameters:
SYNC_STAGES, 2, number of flops in each per-domain enable synchronizer chain; minimum 2.

Ports:
clk0_i  input  1  primary clock (the block's one clock); source 0; default-selected source
arst_ni  input  1  reset, asynchronous, active-low; clears both enables
sel_i  input  1  source select: 0 = clk0_i, 1 = clk1_i; asynchronous to both clocks
clk1_i  input  1  second source clock, asynchronous to clk0_i; multiplexed as a source only
clk_o  output  1  muxed output clock

Behaviour:
- Interface: one clock (clk0_i); reset arst_ni is asynchronous and active-low. clk1_i has its own enable chain but is only a multiplexed source.
- Internal enables: signals named en0 and en1 hold the final stage of each chain. Benches probe them hierarchically.
- Channel 0 chain: SYNC_STAGES flops clocked on the falling edge of clk0_i. Input is (~sel_i & ~en1). en0 is the last stage.
- Channel 1 chain: SYNC_STAGES flops clocked on the falling edge of clk1_i. Input is (sel_i & ~en0). en1 is the last stage.
- Cross-coupling: each chain's first stage samples the opposite enable. That sample is treated as asynchronous and is resynchronized by the chain.
- Output: clk_o = (clk0_i & en0) | (clk1_i & en1), built purely combinationally. No other logic sits in the clock path.
- Reset: while arst_ni = 0, all chain flops are 0, so en0 = en1 = 0 and clk_o = 0.
- Reset release with sel_i = 0: en0 rises after SYNC_STAGES falling edges of clk0_i. The first full clk0_i high phase then appears on clk_o.
- Enable timing: each enable changes only right after its clock's falling edge, i.e. while that source is low. Hence clk_o never truncates a high phase and never starts a partial one.
- Switch latency 0→1: en0 drops within SYNC_STAGES falling edges of clk0_i after sel_i rises. en1 rises within SYNC_STAGES falling edges of clk1_i after en0 is seen low. clk_o stays low during the gap.
- Switch latency 1→0: symmetric.
- Mutual exclusion: en0 and en1 are never both 1 at any time.
- Pulse width: every clk_o high or low phase is ≥ the shorter half-period of the two sources. Nothing under 4 ns with 5 ns half-periods.
- sel_i toggling faster than the handshake: the chains settle on the last stable value. There is no glitch, and clk_o may idle low until settled.
- Reset mid-operation: both enables clear asynchronously and clk_o drops to 0 immediately. Because both sources are low-gated, a drop during a high phase yields a shortened high phase; this is accepted only at reset assertion. After release, selection restarts per the current sel_i.
- A stopped source clock while selected, or while its enable must drop, blocks the switch. This is documented behaviour.
- clk_o is never X/Z once arst_ni has been asserted.

Test Plan:
- Reset: arst_ni = 0 for 20 ns, sel_i = 0, both clocks at 10 ns period → clk_o = 0 and en0 = en1 = 0. After release, en0 = 1 within 2 clk0 falling edges, and clk_o follows clk0_i (5 ns high / 5 ns low).
- Steady clk0, then switch: hold sel_i = 0 for 200 ns, then set sel_i = 1 → en0 falls, a low gap follows, then en1 rises. clk_o follows clk1_i. en0 & en1 is never 1, and no posedge-to-posedge interval on clk_o is under 4 ns.
- Switch back: sel_i 1→0 after 200 ns → symmetric handover to clk0_i with the same no-overlap and no-runt checks.
- Fast toggle: invert sel_i every 15 ns, 10 times → no X on clk_o, no overlap, no pulse < 4 ns. The final selection matches the last sel_i.
- Random: 20 sel_i changes at random 10–50 ns intervals, with clk1_i at a 14 ns period asynchronous to clk0_i → zero overlap, X, or runt errors.
- Reset mid-run: drive arst_ni low for 15 ns during clocking → clk_o = 0 immediately. After release, the clock resumes on the source given by sel_i within 2 falling edges of that source.

Source files
------------

// File: rtl/glitchfree_clk_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// glitchfree_clk_mux
//
// Glitch-free 2:1 clock multiplexer for two mutually asynchronous sources.
// Each source owns an enable synchronizer chain clocked on that source's
// falling edge. An enable therefore only changes while its own source is low.
// On a switch, the outgoing source is released first. The incoming source is
// granted only after the outgoing chain has fully emptied. As a result clk_o
// never carries a runt pulse and never sees both sources at once.
//
// Ports:
//   clk0_i   in   source clock 0; default-selected source
//   arst_ni  in   asynchronous active-low reset; clears both enable chains
//   sel_i    in   source select (0 = clk0_i, 1 = clk1_i); asynchronous
//   clk1_i   in   source clock 1, asynchronous to clk0_i
//   clk_o    out  multiplexed output clock
//
// Parameters:
//   SYNC_STAGES  flops per enable chain (minimum 2)
// -----------------------------------------------------------------------------
module glitchfree_clk_mux #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk0_i,
    input  logic arst_ni,
    input  logic sel_i,
    input  logic clk1_i,
    output logic clk_o
);

    logic [SYNC_STAGES-1:0] sync0_q;
    logic [SYNC_STAGES-1:0] sync0_d;
    logic [SYNC_STAGES-1:0] sync1_q;
    logic [SYNC_STAGES-1:0] sync1_d;
    logic                   busy0;
    logic                   busy1;
    logic                   en0;
    logic                   en1;

    assign en0 = sync0_q[SYNC_STAGES-1];
    assign en1 = sync1_q[SYNC_STAGES-1];

    // A chain counts as busy while any of its stages holds a request, not
    // only its last stage. Without this, a short sel_i pulse could leave a
    // request in flight in one chain while the other chain starts. Both
    // enables would then reach 1 together. In steady state the early stages
    // empty before the last one, so busy falls together with the enable and
    // the handover latency is unchanged.
    always_comb begin
        busy0   = |sync0_q;
        busy1   = |sync1_q;
        sync0_d = {sync0_q[SYNC_STAGES-2:0], (~sel_i & ~busy1)};
        sync1_d = {sync1_q[SYNC_STAGES-2:0], (sel_i & ~busy0)};
    end

    // Channel 0 chain: falling edge of clk0_i, so en0 moves only while clk0_i is low.
    always_ff @(negedge clk0_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync0_q <= '0;
        end else begin
            sync0_q <= sync0_d;
        end
    end

    // Channel 1 chain: falling edge of clk1_i, so en1 moves only while clk1_i is low.
    always_ff @(negedge clk1_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= sync1_d;
        end
    end

    // Pure AND-OR gating. Nothing else sits in the clock path.
    assign clk_o = (clk0_i & en0) | (clk1_i & en1);

endmodule

// File: tb/tb_glitchfree_clk_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_glitchfree_clk_mux
//
// Directed stimulus for the glitch-free clock mux. It covers reset, both
// handovers, fast select toggling, random select changes with a 14 ns clk1,
// and reset during clocking. Expected values are queued by the stimulus and
// drained by a separate monitor. Overlap, X and pulse-width checks run
// continuously alongside.
// -----------------------------------------------------------------------------
module tb_glitchfree_clk_mux;

    logic clk0_i  = 1'b0;
    logic clk1_i  = 1'b0;
    logic arst_ni = 1'b0;
    logic sel_i   = 1'b0;
    logic clk_o;
    int   hp1     = 5;

    int n_chk  = 0;
    int n_fail = 0;

    // sig: 0 = clk_o, 1 = en0, 2 = en1
    typedef struct {
        string name;
        int    sig;
        logic  exp;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;

    glitchfree_clk_mux #(.SYNC_STAGES(2)) dut (
        .clk0_i  (clk0_i),
        .arst_ni (arst_ni),
        .sel_i   (sel_i),
        .clk1_i  (clk1_i),
        .clk_o   (clk_o)
    );

    wire en0_w = dut.en0;
    wire en1_w = dut.en1;

    initial forever #5 clk0_i = ~clk0_i;

    initial begin
        #2;
        forever #(hp1) clk1_i = ~clk1_i;
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic act;
                e = sb_q.pop_front();
                case (e.sig)
                    0:       act = clk_o;
                    1:       act = en0_w;
                    default: act = en1_w;
                endcase
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s at %0t: got %b expected %b", e.name, $time, act, e.exp);
                end
            end
        end
    end

    // ---------------- continuous checks ----------------
    always @(en0_w or en1_w) begin
        n_chk++;
        if (en0_w && en1_w) begin
            n_fail++;
            $display("FAIL overlap at %0t: en0=%b en1=%b required not both 1", $time, en0_w, en1_w);
        end
    end

    always @(clk_o) begin
        n_chk++;
        if ($isunknown(clk_o)) begin
            n_fail++;
            $display("FAIL clk_o_known at %0t: got %b required 0 or 1", $time, clk_o);
        end
    end

    realtime last_rise = 0.0;
    realtime last_fall = 0.0;
    bit      have_rise = 1'b0;
    bit      have_fall = 1'b0;

    always @(posedge clk_o) begin
        n_chk++;
        if (have_rise && (($realtime - last_rise) < 4.0)) begin
            n_fail++;
            $display("FAIL rise_to_rise at %0t: got %0.2f ns required >= 4 ns", $time, $realtime - last_rise);
        end
        n_chk++;
        if (have_fall && (($realtime - last_fall) < 4.0)) begin
            n_fail++;
            $display("FAIL low_phase at %0t: got %0.2f ns required >= 4 ns", $time, $realtime - last_fall);
        end
        last_rise = $realtime;
        have_rise = 1'b1;
    end

    always @(negedge clk_o) begin
        // A high phase cut short by reset assertion is accepted.
        if (arst_ni) begin
            n_chk++;
            if (have_rise && (($realtime - last_rise) < 4.0)) begin
                n_fail++;
                $display("FAIL high_phase at %0t: got %0.2f ns required >= 4 ns", $time, $realtime - last_rise);
            end
        end
        last_fall = $realtime;
        have_fall = 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic sb_push(input string nm, input int sig, input logic exp);
        exp_t e;
        e.name = nm;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_flush();
        -> chk_ev;
    endtask

    // Change sel_i on a half-ns point so it never coincides with a clock edge.
    task automatic set_sel(input logic v);
        @(posedge clk0_i);
        #2.5;
        sel_i = v;
    endtask

    task automatic follows_clk0(input string nm);
        @(posedge clk0_i);
        #1;
        sb_push({nm, "_hi"}, 0, 1'b1);
        sb_push({nm, "_en0"}, 1, 1'b1);
        sb_push({nm, "_en1"}, 2, 1'b0);
        sb_flush();
        @(negedge clk0_i);
        #1;
        sb_push({nm, "_lo"}, 0, 1'b0);
        sb_flush();
    endtask

    task automatic follows_clk1(input string nm);
        @(posedge clk1_i);
        #1;
        sb_push({nm, "_hi"}, 0, 1'b1);
        sb_push({nm, "_en0"}, 1, 1'b0);
        sb_push({nm, "_en1"}, 2, 1'b1);
        sb_flush();
        @(negedge clk1_i);
        #1;
        sb_push({nm, "_lo"}, 0, 1'b0);
        sb_flush();
    endtask

    task automatic follows_sel(input string nm);
        if (sel_i) follows_clk1(nm);
        else       follows_clk0(nm);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog: got no finish by 20000 ns, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with sel_i = 0.
        #19.5;
        sb_push("rst_clk_o", 0, 1'b0);
        sb_push("rst_en0",   1, 1'b0);
        sb_push("rst_en1",   2, 1'b0);
        sb_flush();
        #1.5;
        arst_ni = 1'b1;

        // en0 rises on the second clk0 falling edge after release.
        repeat (2) @(negedge clk0_i);
        #1;
        sb_push("rel_en0", 1, 1'b1);
        sb_push("rel_en1", 2, 1'b0);
        sb_flush();
        follows_clk0("rel_follow0");

        // Switch 0 -> 1.
        #150;
        set_sel(1'b1);
        repeat (2) @(negedge clk0_i);
        #1;
        sb_push("sw01_en0_off", 1, 1'b0);
        sb_flush();
        #5;
        // clk0 is high here, yet the output must stay parked low.
        sb_push("sw01_gap", 0, 1'b0);
        sb_push("sw01_gap_en1", 2, 1'b0);
        sb_flush();
        @(negedge clk1_i);
        #1;
        sb_push("sw01_en1_on", 2, 1'b1);
        sb_flush();
        follows_clk1("sw01_follow1");

        // Switch 1 -> 0.
        #150;
        set_sel(1'b0);
        repeat (2) @(negedge clk1_i);
        #1;
        sb_push("sw10_en1_off", 2, 1'b0);
        sb_flush();
        #3;
        sb_push("sw10_gap", 0, 1'b0);
        sb_flush();
        repeat (2) @(negedge clk0_i);
        #1;
        sb_push("sw10_en0_on", 1, 1'b1);
        sb_flush();
        follows_clk0("sw10_follow0");

        // Fast toggle: 10 inversions at 15 ns spacing, ending on sel_i = 0.
        set_sel(~sel_i);
        for (int i = 1; i < 10; i++) begin
            #15;
            sel_i = ~sel_i;
        end
        #120;
        follows_sel("fast_final");

        // Random select changes with a 14 ns clk1.
        hp1 = 7;
        set_sel(sel_i);
        for (int i = 0; i < 20; i++) begin
            #($urandom_range(10, 50));
            sel_i = ~sel_i;
        end
        #150;
        follows_sel("rand_final");

        // Reset during a clk_o high phase, with sel_i moved to 1 while held.
        sel_i = 1'b0;
        #60;
        @(posedge clk0_i);
        #2.5;
        arst_ni = 1'b0;
        #0.5;
        sb_push("midrst_clk_o", 0, 1'b0);
        sb_push("midrst_en0",   1, 1'b0);
        sb_push("midrst_en1",   2, 1'b0);
        sb_flush();
        #6;
        sel_i = 1'b1;
        #8.5;
        arst_ni = 1'b1;
        repeat (2) @(negedge clk1_i);
        #1;
        sb_push("midrst_en1_on", 2, 1'b1);
        sb_push("midrst_en0_off", 1, 1'b0);
        sb_flush();
        follows_clk1("midrst_follow1");

        #5;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
